uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter of the Nexys top level between two byte sources, A and B, under a round-robin policy with bounded bursts. Each requester uses a valid/ready byte handshake. The block sequences the transmitter through a start pulse and busy-flag handshake, and supervises the start with a timeout. It sits between the memory-mapped peripheral logic and the UART TX core.

---
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core between byte sources A and B, round robin with bounded bursts
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   req_valid/data/ready_{a,b}    per-requester valid/ready byte handshake; ready is a same-cycle accept pulse
//   uart_tx_start/data/busy       start pulse, held byte and busy flag of the UART TX core
//   arb_busy, grant_b             byte in flight, current owner (1 = B)
//   timeout_err                   pulse when busy fails to rise after a start
// Macro UART_ARB_FIXED_PRIO_EN: A always wins contention instead of round robin.
module uart_tx_arbiter #(
    parameter int MAX_BURST     = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid_a,
    input  logic [7:0] req_data_a,
    output logic       req_ready_a,
    input  logic       req_valid_b,
    input  logic [7:0] req_data_b,
    output logic       req_ready_b,
    output logic       uart_tx_start,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_busy,
    output logic       arb_busy,
    output logic       grant_b,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
    state_t      state_q;
    logic [7:0]  data_q, burst_q, data_d, burst_d;
    logic [15:0] timer_q;
    logic        grant_q, last_q, start_q, tmo_q;
    logic        pick_b, idle_acc, cont, acc_a, acc_b;
`ifdef UART_ARB_FIXED_PRIO_EN
    assign pick_b = req_valid_b && !req_valid_a;
`else
    assign pick_b = req_valid_b && (!req_valid_a || !last_q);
`endif
    assign idle_acc = state_q == IDLE && (req_valid_a || req_valid_b);
    // the owner keeps the transmitter on the busy-fall cycle while its burst budget lasts
    assign cont = state_q == WAIT_DONE && !uart_tx_busy && burst_q < 8'(MAX_BURST) &&
                  (grant_q ? req_valid_b : req_valid_a);
    // reset suppresses acceptance so no byte is handshaken away during reset
    assign acc_a = !reset && ((idle_acc && !pick_b) || (cont && !grant_q));
    assign acc_b = !reset && ((idle_acc && pick_b) || (cont && grant_q));
    assign data_d  = acc_b ? req_data_b : req_data_a;
    assign burst_d = state_q == IDLE ? 8'd1 : burst_q + 8'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            burst_q <= '0;
            timer_q <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            start_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            tmo_q   <= 1'b0;
            if (acc_a || acc_b) begin
                state_q <= START;
                data_q  <= data_d;
                grant_q <= acc_b;
                burst_q <= burst_d;
                start_q <= 1'b1;
            end else begin
                case (state_q)
                    START: begin
                        state_q <= WAIT_BUSY;
                        timer_q <= '0;
                    end
                    WAIT_BUSY: begin
                        if (uart_tx_busy) begin
                            state_q <= WAIT_DONE;
                        end else if (timer_q == 16'(START_TIMEOUT - 1)) begin
                            tmo_q   <= 1'b1;
                            last_q  <= grant_q;
                            burst_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                    WAIT_DONE: begin
                        if (!uart_tx_busy) begin
                            last_q  <= grant_q;
                            burst_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    assign req_ready_a   = acc_a;
    assign req_ready_b   = acc_b;
    assign uart_tx_start = start_q;
    assign uart_tx_data  = data_q;
    assign arb_busy      = state_q != IDLE;
    assign grant_b       = grant_q;
    assign timeout_err   = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors and sequences for uart_tx_arbiter with a UART busy model
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       reset, req_valid_a, req_valid_b, req_ready_a, req_ready_b;
    logic [7:0] req_data_a, req_data_b, uart_tx_data;
    logic       uart_tx_start, uart_tx_busy, arb_busy, grant_b, timeout_err;
    int n_tests = 0, n_fail = 0, cyc = 0, since = -1, mode = 0, last_fall = -1, end_cyc = -1;
    logic busy_prev = 1'b0;
    logic [7:0] qa[$], qb[$], tx_data[$];
    logic       tx_gb[$];
    int         tx_gap[$], tx_cyc[$], tmo_cyc[$], rdy_cyc[$];
    typedef struct {
        bit pre, va, vb;
        logic [7:0] da, db;
        bit ra, rb, st, gb;
        logic [7:0] data;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid_a(req_valid_a), .req_data_a(req_data_a), .req_ready_a(req_ready_a),
        .req_valid_b(req_valid_b), .req_data_b(req_data_b), .req_ready_b(req_ready_b),
        .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
        .arb_busy(arb_busy), .grant_b(grant_b), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // UART model: busy high from 2 to 11 cycles after a start (mode 0), never busy (mode 1)
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (uart_tx_start) since = 0;
        else if (since >= 0 && since < 11) since++;
        else since = -1;
        uart_tx_busy = (mode == 0) && since >= 2 && since <= 11;
        if (busy_prev && !uart_tx_busy) last_fall = cyc;
        busy_prev = uart_tx_busy;
    endtask

    task automatic clear_logs();
        tx_data.delete(); tx_gb.delete(); tx_gap.delete(); tx_cyc.delete();
        tmo_cyc.delete(); rdy_cyc.delete(); end_cyc = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_data_a = '0; req_data_b = '0;
        qa.delete(); qb.delete(); mode = 0; since = -1; uart_tx_busy = 1'b0; busy_prev = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // streams the queued bytes through the valid/ready handshake until everything drains
    task automatic run(input int budget);
        int n = 0;
        bit done = 0, prev_rdy = 0;
        logic [7:0] prev_data = uart_tx_data;
        while (!done && n < budget) begin
            tick(); n++;
            req_valid_a = qa.size() > 0;
            req_valid_b = qb.size() > 0;
            if (req_valid_a) req_data_a = qa[0];
            if (req_valid_b) req_data_b = qb[0];
            #1;
            check("one_ready", int'(req_ready_a & req_ready_b), 0);
            check("ready_needs_valid", int'((req_ready_a & !req_valid_a) | (req_ready_b & !req_valid_b)), 0);
            if (uart_tx_data != prev_data) check("data_hold", int'(prev_rdy), 1);
            if (uart_tx_start) begin
                tx_data.push_back(uart_tx_data); tx_gb.push_back(grant_b);
                tx_gap.push_back(cyc - last_fall); tx_cyc.push_back(cyc);
            end
            if (timeout_err) tmo_cyc.push_back(cyc);
            if (req_ready_a || req_ready_b) rdy_cyc.push_back(cyc);
            prev_rdy = req_ready_a | req_ready_b;
            prev_data = uart_tx_data;
            if (req_ready_a) void'(qa.pop_front());
            if (req_ready_b) void'(qb.pop_front());
            done = qa.size() == 0 && qb.size() == 0 && !arb_busy && !req_ready_a && !req_ready_b && !uart_tx_busy;
        end
        if (done) end_cyc = cyc;
        else check("run_budget", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ed[9];
        int eg[9];
        bit egb[9];
        vt[0] = '{0, 1, 0, 8'h41, 8'hC1, 1, 0, 1, 0, 8'h41};
        vt[1] = '{0, 0, 1, 8'h42, 8'hC2, 0, 1, 1, 1, 8'hC2};
        vt[2] = '{0, 1, 1, 8'h43, 8'hC3, 1, 0, 1, 0, 8'h43};
`ifdef UART_ARB_FIXED_PRIO_EN
        vt[3] = '{1, 1, 1, 8'h44, 8'hC4, 1, 0, 1, 0, 8'h44};
`else
        vt[3] = '{1, 1, 1, 8'h44, 8'hC4, 0, 1, 1, 1, 8'hC4};
`endif
        vt[4] = '{0, 0, 0, 8'h45, 8'hC5, 0, 0, 0, 0, 8'h00};
        vt[5] = '{1, 1, 0, 8'h46, 8'hC6, 1, 0, 1, 0, 8'h46};
        vt[6] = '{1, 0, 0, 8'h47, 8'hC7, 0, 0, 0, 0, 8'h5A};

        do_reset();
        #1;
        check("rst_arb_busy", int'(arb_busy), 0);
        check("rst_start", int'(uart_tx_start), 0);
        check("rst_data", int'(uart_tx_data), 0);
        check("rst_grant_b", int'(grant_b), 0);
        check("rst_timeout", int'(timeout_err), 0);
        check("rst_ready", int'(req_ready_a | req_ready_b), 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            if (vt[i].pre) begin
                qa.push_back(8'h5A);
                run(300);
            end
            tick();
            req_valid_a = vt[i].va; req_data_a = vt[i].da;
            req_valid_b = vt[i].vb; req_data_b = vt[i].db;
            #1;
            check($sformatf("vec%0d_ready_a", i), int'(req_ready_a), int'(vt[i].ra));
            check($sformatf("vec%0d_ready_b", i), int'(req_ready_b), int'(vt[i].rb));
            tick();
            req_valid_a = 1'b0; req_valid_b = 1'b0;
            #1;
            check($sformatf("vec%0d_start", i), int'(uart_tx_start), int'(vt[i].st));
            check($sformatf("vec%0d_arb_busy", i), int'(arb_busy), int'(vt[i].st));
            check($sformatf("vec%0d_data", i), int'(uart_tx_data), int'(vt[i].data));
            check($sformatf("vec%0d_grant_b", i), int'(grant_b), int'(vt[i].gb));
            run(300);
        end

        do_reset(); clear_logs();
        qa.push_back(8'h41);
        run(300);
        check("single_tx_count", tx_data.size(), 1);
        check("single_ready_count", rdy_cyc.size(), 1);
        if (tx_data.size() == 1 && rdy_cyc.size() == 1) begin
            check("single_data", int'(tx_data[0]), 8'h41);
            check("single_grant_b", int'(tx_gb[0]), 0);
            check("single_latency", tx_cyc[0] - rdy_cyc[0], 1);
        end
        check("single_idle_after_fall", end_cyc - last_fall, 1);

        do_reset(); clear_logs();
        for (int i = 0; i < 8; i++) begin
            qa.push_back(8'(8'h10 + i));
            qb.push_back(8'(8'h20 + i));
        end
        run(1000);
        check("cont_tx_count", tx_data.size(), 16);
        if (tx_data.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                int own, exp_d;
`ifdef UART_ARB_FIXED_PRIO_EN
                own = i >= 8;
                exp_d = own ? 8'h20 + i - 8 : 8'h10 + i;
`else
                own = (i / 4) % 2;
                exp_d = (own ? 8'h20 : 8'h10) + (i / 8) * 4 + i % 4;
`endif
                check($sformatf("cont_data%0d", i), int'(tx_data[i]), exp_d);
                check($sformatf("cont_grant%0d", i), int'(tx_gb[i]), own);
                if (i > 0) check($sformatf("cont_gap%0d", i), tx_gap[i], (i % 4 == 0) ? 2 : 1);
            end
        end

        do_reset(); clear_logs();
        for (int i = 0; i < 8; i++) qa.push_back(8'(i));
        qb.push_back(8'hB0);
`ifdef UART_ARB_FIXED_PRIO_EN
        ed = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hB0};
        egb = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        eg = '{0, 1, 1, 1, 2, 1, 1, 1, 2};
`else
        ed = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hB0, 8'h04, 8'h05, 8'h06, 8'h07};
        egb = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        eg = '{0, 1, 1, 1, 2, 2, 1, 1, 1};
`endif
        run(1000);
        check("burst_tx_count", tx_data.size(), 9);
        if (tx_data.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("burst_data%0d", i), int'(tx_data[i]), int'(ed[i]));
                check($sformatf("burst_grant%0d", i), int'(tx_gb[i]), int'(egb[i]));
                if (i > 0) check($sformatf("burst_gap%0d", i), tx_gap[i], eg[i]);
            end
        end

        do_reset(); clear_logs();
        mode = 1;
        qa.push_back(8'h55);
        run(300);
        check("tmo_pulses", tmo_cyc.size(), 1);
        check("tmo_tx_count", tx_cyc.size(), 1);
        if (tmo_cyc.size() == 1 && tx_cyc.size() == 1) check("tmo_latency", tmo_cyc[0] - tx_cyc[0], 17);
        mode = 0; clear_logs();
        qa.push_back(8'h66);
        run(300);
        check("post_tmo_tx_count", tx_data.size(), 1);
        if (tx_data.size() == 1) check("post_tmo_data", int'(tx_data[0]), 8'h66);
        check("post_tmo_no_timeout", tmo_cyc.size(), 0);

        do_reset();
        tick();
        req_valid_a = 1'b1; req_data_a = 8'h77;
        #1;
        check("mid_first_ready", int'(req_ready_a), 1);
        tick();
        req_valid_a = 1'b0;
        tick(); tick(); tick();
        #1;
        check("mid_in_flight", int'(arb_busy & uart_tx_busy), 1);
        tick();
        uart_tx_busy = 1'b0; busy_prev = 1'b0; since = -1;
        reset = 1'b1;
        req_valid_a = 1'b1; req_data_a = 8'h78;
        req_valid_b = 1'b1; req_data_b = 8'h79;
        #1;
        check("mid_rst_ready_a", int'(req_ready_a), 0);
        check("mid_rst_ready_b", int'(req_ready_b), 0);
        tick();
        #1;
        check("mid_rst_arb_busy", int'(arb_busy), 0);
        check("mid_rst_data", int'(uart_tx_data), 0);
        check("mid_rst_start", int'(uart_tx_start), 0);
        check("mid_rst_grant_b", int'(grant_b), 0);
        reset = 1'b0;
        #1;
        check("mid_after_ready_a", int'(req_ready_a), 1);
        check("mid_after_ready_b", int'(req_ready_b), 0);
        tick();
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        #1;
        check("mid_after_start", int'(uart_tx_start), 1);
        check("mid_after_data", int'(uart_tx_data), 8'h78);
        check("mid_after_grant_b", int'(grant_b), 0);
        run(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
